// File: rtl/axis_arbiter2.sv
// axis_arbiter2: two-input round-robin arbiter for 8-bit AXI-stream bytes.
// A grant covers one burst. The burst ends on ilast, when MAX_BURST bytes
// have been accepted, or after IDLE_TIMEOUT consecutive idle cycles.
// The selected bytes leave through a registered output stage.
// Optional macro AXIS_ARB_TAG_EN: when the granted channel changes, a channel
// tag byte (TAG_BASE | n) is sent before the burst.
module axis_arbiter2 #(
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter logic [7:0]  TAG_BASE     = 8'hF0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata0,
    input  logic       ivalid0,
    input  logic       ilast0,
    output logic       iready0,
    input  logic [7:0] idata1,
    input  logic       ivalid1,
    input  logic       ilast1,
    output logic       iready1,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    output logic [1:0] grant
);

`ifdef AXIS_ARB_TAG_EN
    typedef enum logic [2:0] {S_IDLE, S_GRANT0, S_GRANT1, S_TAG0, S_TAG1} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_t;
`endif

    localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);
    localparam logic [7:0] LP_IDLE_TO   = 8'(IDLE_TIMEOUT);

    // Bit 0 of the tag byte carries the channel number, so TAG_BASE must leave it clear.
    if (MAX_BURST < 1 || MAX_BURST > 255 || IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255 ||
        TAG_BASE[0] != 1'b0) begin : g_param_check
        $error("axis_arbiter2: parameter out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_odata;
    logic       r_ovalid;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_idle_cnt;
    logic       r_last_ptr;
    logic [7:0] w_burst_nxt;
    logic [7:0] w_idle_nxt;
    logic       w_ptr_nxt;
    logic       w_load;
    logic [7:0] w_load_data;
    logic       w_pick;
    logic       w_out_free;
    logic       w_xfer0;
    logic       w_xfer1;
    logic       w_gch;
    logic       w_gvalid;
    logic       w_glast;
    logic [7:0] w_gdata;
    logic       w_gxfer;
`ifdef AXIS_ARB_TAG_EN
    logic       r_tag_ch;
    logic       r_tag_seen;
    logic       w_tag_ch_nxt;
    logic       w_tag_seen_nxt;
    logic       w_tch;
`endif

    assign w_out_free = !r_ovalid || oready;
    assign iready0    = (r_state == S_GRANT0) && w_out_free;
    assign iready1    = (r_state == S_GRANT1) && w_out_free;
    assign w_xfer0    = ivalid0 && iready0;
    assign w_xfer1    = ivalid1 && iready1;
    assign w_gch      = (r_state == S_GRANT1);
    assign w_gvalid   = w_gch ? ivalid1 : ivalid0;
    assign w_glast    = w_gch ? ilast1 : ilast0;
    assign w_gdata    = w_gch ? idata1 : idata0;
    assign w_gxfer    = w_xfer0 || w_xfer1;
    assign odata      = r_odata;
    assign ovalid     = r_ovalid;
`ifdef AXIS_ARB_TAG_EN
    assign w_tch      = (r_state == S_TAG1);
`endif

    // Next-state, counter and output-load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_ptr_nxt   = r_last_ptr;
        w_load      = 1'b0;
        w_load_data = r_odata;
        w_pick      = 1'b0;
`ifdef AXIS_ARB_TAG_EN
        w_tag_ch_nxt   = r_tag_ch;
        w_tag_seen_nxt = r_tag_seen;
`endif
        case (r_state)
            S_IDLE: begin
                // Counters are held at zero so every grant starts from a clean count.
                w_burst_nxt = '0;
                w_idle_nxt  = '0;
                if (ivalid0 || ivalid1) begin
                    w_pick      = (ivalid0 && ivalid1) ? ~r_last_ptr : ivalid1;
                    w_state_nxt = w_pick ? S_GRANT1 : S_GRANT0;
`ifdef AXIS_ARB_TAG_EN
                    if (!r_tag_seen || (r_tag_ch != w_pick)) begin
                        w_state_nxt = w_pick ? S_TAG1 : S_TAG0;
                    end
`endif
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (w_gxfer) begin
                    w_load      = 1'b1;
                    w_load_data = w_gdata;
                    w_idle_nxt  = '0;
                    if (r_burst_cnt != 8'hFF) begin
                        w_burst_nxt = r_burst_cnt + 8'd1;
                    end
                    if (w_glast || (w_burst_nxt == LP_MAX_BURST)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_gch;
                    end
                end else if (w_gvalid) begin
                    // Valid but back-pressured: the requester is not idle.
                    w_idle_nxt = '0;
                end else begin
                    if (r_idle_cnt != 8'hFF) begin
                        w_idle_nxt = r_idle_cnt + 8'd1;
                    end
                    if (w_idle_nxt == LP_IDLE_TO) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_gch;
                    end
                end
            end
`ifdef AXIS_ARB_TAG_EN
            S_TAG0, S_TAG1: begin
                w_burst_nxt = '0;
                w_idle_nxt  = '0;
                if (w_out_free) begin
                    w_load         = 1'b1;
                    w_load_data    = TAG_BASE | {7'b0, w_tch};
                    w_tag_ch_nxt   = w_tch;
                    w_tag_seen_nxt = 1'b1;
                    w_state_nxt    = w_tch ? S_GRANT1 : S_GRANT0;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Debug grant indication, one-hot per channel currently owning the output
    always_comb begin
        grant = 2'b00;
        case (r_state)
            S_GRANT0: grant = 2'b01;
            S_GRANT1: grant = 2'b10;
`ifdef AXIS_ARB_TAG_EN
            S_TAG0:   grant = 2'b01;
            S_TAG1:   grant = 2'b10;
`endif
            default:  grant = 2'b00;
        endcase
    end

    // State, counters and round-robin pointer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
            r_last_ptr  <= 1'b1;
`ifdef AXIS_ARB_TAG_EN
            r_tag_ch    <= 1'b0;
            r_tag_seen  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_last_ptr  <= w_ptr_nxt;
`ifdef AXIS_ARB_TAG_EN
            r_tag_ch    <= w_tag_ch_nxt;
            r_tag_seen  <= w_tag_seen_nxt;
`endif
        end
    end

    // Output register: loads when free, holds while stalled, drains on handshake
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ovalid <= 1'b0;
            r_odata  <= '0;
        end else if (w_load) begin
            r_ovalid <= 1'b1;
            r_odata  <= w_load_data;
        end else if (oready) begin
            r_ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_arbiter2.sv
// Testbench for axis_arbiter2 (MAX_BURST=4, IDLE_TIMEOUT=16).
// Honours AXIS_ARB_TAG_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_axis_arbiter2;
    localparam int unsigned MB = 4;
    localparam int unsigned TO = 16;
    localparam logic [7:0]  TB_TAG_BASE = 8'hF0;
`ifdef AXIS_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
    localparam int TAGD   = 1;
`else
    localparam bit TAG_EN = 1'b0;
    localparam int TAGD   = 0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] idata0 = '0, idata1 = '0;
    logic       ivalid0 = 1'b0, ivalid1 = 1'b0, ilast0 = 1'b0, ilast1 = 1'b0;
    logic       iready0, iready1;
    logic [7:0] odata;
    logic       ovalid;
    logic       oready = 1'b0;
    logic [1:0] grant;

    always #5 clock = ~clock;

    axis_arbiter2 #(.MAX_BURST(MB), .IDLE_TIMEOUT(TO), .TAG_BASE(TB_TAG_BASE)) dut (
        .clock(clock), .resetn(resetn),
        .idata0(idata0), .ivalid0(ivalid0), .ilast0(ilast0), .iready0(iready0),
        .idata1(idata1), .ivalid1(ivalid1), .ilast1(ilast1), .iready1(iready1),
        .odata(odata), .ovalid(ovalid), .oready(oready), .grant(grant)
    );

    int vectors = 0;
    int miscompares = 0;

    // Per-channel byte streams: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int vprob = 100;
    int rprob = 100;
    int force_rdy = -1;
    bit drv_en = 1'b0;

    // Behavioural reference: owner channel (-1 none), pending tag channel, pointer, counts
    int         m_owner, m_tagpend, m_lasttag, m_burst, m_idle, m_ptr;
    bit         m_ovalid;
    logic [7:0] m_odata;
    bit         m_acc[2];

    task automatic model_reset();
        m_owner = -1; m_tagpend = -1; m_lasttag = -1;
        m_burst = 0; m_idle = 0; m_ptr = 1;
        m_ovalid = 1'b0; m_odata = '0;
        m_acc[0] = 1'b0; m_acc[1] = 1'b0;
    endtask

    function automatic logic [1:0] m_grant();
        int g;
        g = (m_owner >= 0) ? m_owner : m_tagpend;
        if (g < 0) return 2'b00;
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    // Advance the reference by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit v0, input bit v1, input bit l0, input bit l1,
                              input logic [7:0] d0, input logic [7:0] d1, input bit r);
        bit v[2];
        bit l[2];
        logic [7:0] d[2];
        bit free, load;
        logic [7:0] ld;
        int c;
        v[0] = v0; v[1] = v1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;
        free = !m_ovalid || r;
        load = 1'b0; ld = '0;
        m_acc[0] = 1'b0; m_acc[1] = 1'b0;
        if (m_tagpend >= 0) begin
            if (free) begin
                load = 1'b1;
                ld = TB_TAG_BASE | 8'(m_tagpend);
                m_lasttag = m_tagpend;
                m_owner = m_tagpend;
                m_tagpend = -1;
            end
        end else if (m_owner < 0) begin
            c = (v[0] && v[1]) ? 1 - m_ptr : (v[0] ? 0 : (v[1] ? 1 : -1));
            if (c >= 0) begin
                m_burst = 0; m_idle = 0;
                if (TAG_EN && m_lasttag != c) m_tagpend = c;
                else m_owner = c;
            end
        end else begin
            c = m_owner;
            if (v[c] && free) begin
                load = 1'b1; ld = d[c]; m_acc[c] = 1'b1;
                m_burst++; m_idle = 0;
                if (l[c] || m_burst == int'(MB)) begin m_owner = -1; m_ptr = c; end
            end else if (v[c]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == int'(TO)) begin m_owner = -1; m_ptr = c; end
            end
        end
        if (load) begin m_ovalid = 1'b1; m_odata = ld; end
        else if (r) m_ovalid = 1'b0;
    endtask

    task automatic drive();
        if (!(ivalid0 && !m_acc[0])) begin
            if (q0.size() > 0 && int'($urandom_range(99)) < vprob) begin
                {ilast0, idata0} = q0.pop_front(); ivalid0 = 1'b1;
            end else begin
                ivalid0 = 1'b0; ilast0 = 1'b0;
            end
        end
        if (!(ivalid1 && !m_acc[1])) begin
            if (q1.size() > 0 && int'($urandom_range(99)) < vprob) begin
                {ilast1, idata1} = q1.pop_front(); ivalid1 = 1'b1;
            end else begin
                ivalid1 = 1'b0; ilast1 = 1'b0;
            end
        end
        if (force_rdy >= 0) oready = (force_rdy != 0);
        else oready = (int'($urandom_range(99)) < rprob);
    endtask

    // One clock: snapshot at negedge, step the model at posedge, drive, return at negedge.
    task automatic cycle();
        bit sv0, sv1, sl0, sl1, sr;
        logic [7:0] sd0, sd1;
        sv0 = ivalid0; sv1 = ivalid1; sl0 = ilast0; sl1 = ilast1;
        sd0 = idata0; sd1 = idata1; sr = oready;
        @(posedge clock);
        model_step(sv0, sv1, sl0, sl1, sd0, sd1, sr);
        #1;
        if (drv_en) drive();
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ivalid0 = 1'b0; ivalid1 = 1'b0; ilast0 = 1'b0; ilast1 = 1'b0;
        idata0 = '0; idata1 = '0; oready = 1'b0;
        q0.delete(); q1.delete();
        drv_en = 1'b0; force_rdy = -1; vprob = 100; rprob = 100;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ivalid0 = 1'b1; ivalid1 = 1'b1; idata0 = 8'h11; idata1 = 8'h22;
        oready = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if (ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b expected 00", grant); end
        vectors++;
        if (iready0 !== 1'b0 || iready1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_iready: got %b%b expected 00", iready1, iready0);
        end
        resetn = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (grant !== 2'b01) begin miscompares++; $display("FAIL reset_first_grant: got %b expected 01", grant); end
    endtask

    task automatic test_basic();
        do_reset();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b1, 8'h42});
        drv_en = 1'b1;
        for (int k = 1; k <= 6 + TAGD; k++) begin
            cycle();
            if (k == 2) begin
                vectors++;
                if (grant !== 2'b01 || ovalid !== 1'b0) begin
                    miscompares++; $display("FAIL basic_grant: grant=%b ovalid=%b expected 01/0", grant, ovalid);
                end
            end
            if (k == 3) begin
                vectors++;
                if (ovalid !== 1'b1 || odata !== (TAG_EN ? 8'hF0 : 8'h41)) begin
                    miscompares++; $display("FAIL basic_first: ovalid=%b odata=%h expected 1/%h",
                                            ovalid, odata, TAG_EN ? 8'hF0 : 8'h41);
                end
            end
            if (k == 3 + TAGD && TAG_EN) begin
                vectors++;
                if (ovalid !== 1'b1 || odata !== 8'h41) begin
                    miscompares++; $display("FAIL basic_data0: ovalid=%b odata=%h expected 1/41", ovalid, odata);
                end
            end
            if (k == 4 + TAGD) begin
                vectors++;
                if (ovalid !== 1'b1 || odata !== 8'h42 || grant !== 2'b00) begin
                    miscompares++; $display("FAIL basic_last: ovalid=%b odata=%h grant=%b expected 1/42/00",
                                            ovalid, odata, grant);
                end
            end
            if (k == 5 + TAGD) begin
                vectors++;
                if (ovalid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: ovalid=%b expected 0", ovalid); end
            end
        end
    endtask

    task automatic test_max_burst();
        logic [7:0] exp[$];
        int got;
        int ch;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            q0.push_back({1'b0, 8'(i)});
            q1.push_back({1'b0, 8'(8'h80 + i)});
        end
        for (int g = 0; g < 6; g++) begin
            ch = g % 2;
            if (TAG_EN) exp.push_back(TB_TAG_BASE | 8'(ch));
            for (int b = 0; b < 4; b++) exp.push_back(8'((ch ? 8'h80 : 8'h00) + (g / 2) * 4 + b));
        end
        drv_en = 1'b1;
        got = 0;
        for (int k = 0; k < 300 && got < exp.size(); k++) begin
            cycle();
            if (iready0 && iready1) begin
                vectors++; miscompares++; $display("FAIL burst_exclusive: iready0=1 iready1=1 expected one-hot");
            end
            if (ovalid && oready) begin
                vectors++;
                if (odata !== exp[got]) begin
                    miscompares++; $display("FAIL burst_seq[%0d]: got %h expected %h", got, odata, exp[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != exp.size()) begin
            miscompares++; $display("FAIL burst_timeout: got %0d bytes expected %0d", got, exp.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        int got;
        bit fv;
        logic [7:0] fd;
        do_reset();
        if (TAG_EN) exp.push_back(TB_TAG_BASE);
        for (int i = 0; i < 8; i++) begin
            q0.push_back({(i == 7), 8'(8'h10 + i)});
            exp.push_back(8'(8'h10 + i));
        end
        drv_en = 1'b1;
        got = 0; fv = 1'b0; fd = '0;
        for (int k = 1; k <= 200 && got < exp.size(); k++) begin
            cycle();
            if (k == 5) force_rdy = 0;
            if (k == 6) begin
                fv = ovalid; fd = odata;
                vectors++;
                if (ovalid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid: got %b expected 1", ovalid); end
            end
            if (k >= 7 && k <= 15) begin
                vectors++;
                if (ovalid !== fv || odata !== fd || iready0 !== 1'b0) begin
                    miscompares++; $display("FAIL bp_frozen: ovalid=%b odata=%h iready0=%b expected %b/%h/0",
                                            ovalid, odata, iready0, fv, fd);
                end
            end
            if (k == 15) force_rdy = -1;
            if (ovalid && oready) begin
                vectors++;
                if (odata !== exp[got]) begin
                    miscompares++; $display("FAIL bp_seq[%0d]: got %h expected %h", got, odata, exp[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != exp.size()) begin
            miscompares++; $display("FAIL bp_count: got %0d bytes expected %0d", got, exp.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        q0.push_back({1'b0, 8'h20});
        q1.push_back({1'b0, 8'h90});
        q1.push_back({1'b1, 8'h91});
        drv_en = 1'b1;
        for (int k = 1; k <= 20 + TAGD; k++) begin
            cycle();
            if (k >= 2 && k <= 18 + TAGD) begin
                vectors++;
                if (grant !== 2'b01) begin miscompares++; $display("FAIL to_hold[%0d]: grant=%b expected 01", k, grant); end
            end
            if (k == 19 + TAGD) begin
                vectors++;
                if (grant !== 2'b00) begin miscompares++; $display("FAIL to_release: grant=%b expected 00", grant); end
            end
            if (k == 20 + TAGD) begin
                vectors++;
                if (grant !== 2'b10) begin miscompares++; $display("FAIL to_regrant: grant=%b expected 10", grant); end
            end
        end
    endtask

`ifdef AXIS_ARB_TAG_EN
    task automatic test_tag();
        logic [7:0] exp[$];
        int got;
        do_reset();
        exp = '{8'hF1, 8'h55, 8'hF0, 8'h66, 8'h77};
        q1.push_back({1'b1, 8'h55});
        drv_en = 1'b1;
        got = 0;
        for (int k = 1; k <= 100 && got < exp.size(); k++) begin
            cycle();
            if (k == 4) begin
                q0.push_back({1'b1, 8'h66});
                q0.push_back({1'b1, 8'h77});
            end
            if (ovalid && oready) begin
                vectors++;
                if (odata !== exp[got]) begin
                    miscompares++; $display("FAIL tag_seq[%0d]: got %h expected %h", got, odata, exp[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != exp.size()) begin
            miscompares++; $display("FAIL tag_count: got %0d bytes expected %0d", got, exp.size());
        end
    endtask
`endif

    task automatic test_random();
        bit e0, e1;
        do_reset();
        vprob = 75; rprob = 70;
        drv_en = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            if (k == 500) vprob = 8;
            if (k == 850) vprob = 90;
            while (q0.size() < 4) q0.push_back({($urandom_range(5) == 0), 8'($urandom)});
            while (q1.size() < 4) q1.push_back({($urandom_range(5) == 0), 8'($urandom)});
            cycle();
            e0 = (m_owner == 0) && (!m_ovalid || oready);
            e1 = (m_owner == 1) && (!m_ovalid || oready);
            vectors++;
            if (grant !== m_grant()) begin
                miscompares++; $display("FAIL rand_grant@%0d: got %b expected %b", k, grant, m_grant());
            end
            vectors++;
            if (iready0 !== e0 || iready1 !== e1) begin
                miscompares++; $display("FAIL rand_iready@%0d: got %b%b expected %b%b", k, iready1, iready0, e1, e0);
            end
            vectors++;
            if (ovalid !== m_ovalid || (m_ovalid && odata !== m_odata)) begin
                miscompares++; $display("FAIL rand_out@%0d: ovalid=%b odata=%h expected %b/%h",
                                        k, ovalid, odata, m_ovalid, m_odata);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_max_burst();
        test_backpressure();
        test_timeout();
`ifdef AXIS_ARB_TAG_EN
        test_tag();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
